// File: rtl/bank_fsm_timed.sv
// Per-bank DRAM controller: open-row tracking, tRCD/tRAS/tWR/tRP/tRFC timers, refresh debt.
// Optional closed-page fallback when BANK_FSM_PAGE_TIMEOUT_EN is defined (adds PAGE_TO).
module bank_fsm_timed #(
  parameter int ROW_W        = 14,
  parameter int COL_W        = 10,
  parameter int T_RCD        = 4,
  parameter int T_RAS        = 10,
  parameter int T_WR         = 5,
  parameter int T_RP         = 4,
  parameter int T_RFC        = 30,
  parameter int T_REFI       = 3900,
  parameter int REF_DEBT_MAX = 4,
  parameter int CNT_W        = 12
`ifdef BANK_FSM_PAGE_TIMEOUT_EN
  ,
  parameter int PAGE_TO      = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_done,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic             req_ap,
  output logic             cmd_valid,
  input  logic             cmd_grant,
  output logic [2:0]       cmd_type,
  output logic [ROW_W-1:0] cmd_addr,
  output logic             row_open,
  output logic [ROW_W-1:0] open_row,
  output logic [2:0]       ref_debt,
  output logic             ref_done
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_ACT, S_TRCD, S_RW, S_OPEN,
    S_WAITPRE, S_PRE, S_TRP, S_REF, S_TRFC
  } state_t;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  // Wait states count down to zero; the entry cycle is part of the wait.
  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'((T_RCD >= 2) ? T_RCD - 2 : 0);
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'((T_RP  >= 2) ? T_RP  - 2 : 0);
  localparam logic [CNT_W-1:0] LD_RFC = CNT_W'((T_RFC >= 1) ? T_RFC - 1 : 0);
  localparam logic [CNT_W-1:0] LD_RAS = CNT_W'((T_RAS >= 1) ? T_RAS - 1 : 0);
  localparam logic [CNT_W-1:0] LD_WR  = CNT_W'((T_WR  >= 1) ? T_WR  - 1 : 0);
  localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);
  localparam logic [2:0]       DEBT_MAX  = 3'(REF_DEBT_MAX);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  function automatic logic [2:0] debt_inc(input logic [2:0] d);
    return (d == DEBT_MAX) ? d : d + 3'd1;
  endfunction

  function automatic logic [2:0] debt_dec(input logic [2:0] d);
    return (d == 3'd0) ? d : d - 3'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, tras_cnt_q, twr_cnt_q, refi_cnt_q;
  logic [2:0]       ref_debt_q;
  logic             row_open_q;
  logic             rw_q, ap_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             accept, hit, ref_forced, ref_need, refi_wrap;
`ifdef BANK_FSM_PAGE_TIMEOUT_EN
  logic [15:0]      page_cnt_q;
`endif

  assign accept     = req_valid & req_ready;
  assign hit        = (req_row == row_q);
  assign ref_forced = (ref_debt_q == DEBT_MAX);
  assign ref_need   = ref_forced || ((ref_debt_q != 3'd0) && !req_valid);
  assign refi_wrap  = (refi_cnt_q == REFI_LAST);

  assign row_open = row_open_q;
  assign open_row = row_open_q ? row_q : '0;
  assign ref_debt = ref_debt_q;
  assign ref_done = (state_q == S_TRFC) && (wait_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = CMD_NOP;
    cmd_addr  = '0;
    case (state_q)
      S_INIT: if (init_done) state_d = S_IDLE;
      S_IDLE: begin
        if (ref_need) begin
          state_d = S_REF;
        end else begin
          req_ready = 1'b1;
          if (req_valid) state_d = S_ACT;
        end
      end
      S_ACT: begin
        cmd_valid = 1'b1;
        cmd_type  = CMD_ACT;
        cmd_addr  = row_q;
        if (cmd_grant) state_d = S_TRCD;
      end
      S_TRCD: if (wait_cnt_q == '0) state_d = S_RW;
      S_RW: begin
        cmd_valid = 1'b1;
        cmd_type  = rw_q ? CMD_RD : CMD_WR;
        cmd_addr  = ROW_W'(col_q);
        if (cmd_grant) state_d = ap_q ? S_WAITPRE : S_OPEN;
      end
      S_OPEN: begin
        req_ready = hit && !ref_forced;
        if (ref_forced) begin
          state_d = S_WAITPRE;
        end else if (req_valid) begin
          state_d = hit ? S_RW : S_WAITPRE;
        end
`ifdef BANK_FSM_PAGE_TIMEOUT_EN
        else if (page_cnt_q == 16'(PAGE_TO - 1)) begin
          state_d = S_WAITPRE;
        end
`endif
      end
      S_WAITPRE: if (tras_cnt_q == '0 && twr_cnt_q == '0) state_d = S_PRE;
      S_PRE: begin
        cmd_valid = 1'b1;
        cmd_type  = CMD_PRE;
        if (cmd_grant) state_d = S_TRP;
      end
      S_TRP: if (wait_cnt_q == '0) state_d = ref_need ? S_REF : S_IDLE;
      S_REF: begin
        cmd_valid = 1'b1;
        cmd_type  = CMD_REF;
        if (cmd_grant) state_d = S_TRFC;
      end
      S_TRFC: if (wait_cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      wait_cnt_q <= '0;
      tras_cnt_q <= '0;
      twr_cnt_q  <= '0;
      refi_cnt_q <= '0;
      ref_debt_q <= 3'd0;
      row_open_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tras_cnt_q <= (state_q == S_ACT && cmd_grant) ? LD_RAS : sat_dec(tras_cnt_q);
      twr_cnt_q  <= (state_q == S_RW && cmd_grant && !rw_q) ? LD_WR : sat_dec(twr_cnt_q);
      if (state_q == S_ACT && cmd_grant)      wait_cnt_q <= LD_RCD;
      else if (state_q == S_PRE && cmd_grant) wait_cnt_q <= LD_RP;
      else if (state_q == S_REF && cmd_grant) wait_cnt_q <= LD_RFC;
      else                                    wait_cnt_q <= sat_dec(wait_cnt_q);
      if (state_q == S_ACT && cmd_grant)      row_open_q <= 1'b1;
      else if (state_q == S_PRE && cmd_grant) row_open_q <= 1'b0;
      refi_cnt_q <= refi_wrap ? '0 : refi_cnt_q + CNT_W'(1);
      // A wrap coinciding with a completed refresh cancels out.
      case ({refi_wrap, ref_done})
        2'b10:   ref_debt_q <= debt_inc(ref_debt_q);
        2'b01:   ref_debt_q <= debt_dec(ref_debt_q);
        default: ref_debt_q <= ref_debt_q;
      endcase
    end
  end

`ifdef BANK_FSM_PAGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) page_cnt_q <= '0;
    else if (state_q == S_OPEN && !accept) page_cnt_q <= page_cnt_q + 16'd1;
    else page_cnt_q <= '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q  <= req_rw;
      ap_q  <= req_ap;
      row_q <= req_row;
      col_q <= req_col;
    end
  end

endmodule
